// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: register-bus widths, memory op encodings and access-size decode.
package mem_access_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [7:0] MEM_NOP = 8'h00;
    localparam logic [7:0] EX_LB   = 8'hE0;
    localparam logic [7:0] EX_LH   = 8'hE1;
    localparam logic [7:0] EX_LW   = 8'hE3;
    localparam logic [7:0] EX_LBU  = 8'hE4;
    localparam logic [7:0] EX_LHU  = 8'hE5;
    localparam logic [7:0] EX_SB   = 8'hE8;
    localparam logic [7:0] EX_SH   = 8'hE9;
    localparam logic [7:0] EX_SW   = 8'hEB;

    function automatic logic [2:0] op_size(input logic [7:0] op);
        case (op)
            EX_LB, EX_LBU, EX_SB: op_size = 3'd1;
            EX_LH, EX_LHU, EX_SH: op_size = 3'd2;
            EX_LW, EX_SW:         op_size = 3'd4;
            default:              op_size = 3'd0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [7:0] op);
        case (op)
            EX_LB, EX_LBU, EX_LH, EX_LHU, EX_LW: op_is_load = 1'b1;
            default:                             op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [7:0] op);
        case (op)
            EX_SB, EX_SH, EX_SW: op_is_store = 1'b1;
            default:             op_is_store = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_ld_ext.sv
// Load extender: turns the little-endian assembled load buffer into the writeback word.
module mem_ld_ext
    import mem_access_pkg::*;
(
    input  logic [7:0]           i_aluop,
    input  logic [REG_BUS_W-1:0] i_buf,
    output logic [REG_BUS_W-1:0] o_wdata
);

    // Sign or zero extend according to the load flavour
    always_comb begin
        o_wdata = 32'h0000_0000;
        case (i_aluop)
            EX_LB:   o_wdata = {{24{i_buf[7]}}, i_buf[7:0]};
            EX_LBU:  o_wdata = {24'h00_0000, i_buf[7:0]};
            EX_LH:   o_wdata = {{16{i_buf[15]}}, i_buf[15:0]};
            EX_LHU:  o_wdata = {16'h0000, i_buf[15:0]};
            EX_LW:   o_wdata = i_buf;
            default: o_wdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: byte-serial little-endian loads/stores over a shared byte port, stalling until done.
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with a misalign_o pulse.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            aluop_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [REG_BUS_W-1:0]  wdata_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  mem_gnt_i,
    input  logic [7:0]            mem_din_i,
    output logic [31:0]           mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    output logic                  mem_req_o,
    output logic                  stall_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_BUS_W-1:0]  wdata_o,
    output logic                  misalign_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_issued;
    logic [2:0]          r_recv;
    logic [31:0]         r_buf;
    logic [RD_LAT-1:0]   r_rd_pipe;

    logic [2:0]  w_size;
    logic        w_load;
    logic        w_store;
    logic        w_memop;
    logic        w_misalign;
    logic        w_start;
    logic        w_active;
    logic        w_req;
    logic        w_fire;
    logic        w_cap;
    logic        w_done_nxt;
    logic [31:0] w_ld_data;

    assign w_size  = op_size(aluop_i);
    assign w_load  = op_is_load(aluop_i);
    assign w_store = op_is_store(aluop_i);
    assign w_memop = w_load || w_store;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (((aluop_i == EX_LH) || (aluop_i == EX_LHU) || (aluop_i == EX_SH)) && mem_addr_i[0])
                     || (((aluop_i == EX_LW) || (aluop_i == EX_SW)) && (mem_addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // The first byte is already requested in the IDLE cycle that sees the op, which sets the latency.
    assign w_start    = (r_state == ST_IDLE) && w_memop && !w_misalign;
    assign w_active   = w_start || (r_state == ST_BUSY);
    assign w_req      = w_active && (r_issued < w_size);
    assign w_fire     = w_req && mem_gnt_i;
    assign w_cap      = r_rd_pipe[RD_LAT-1];
    assign w_done_nxt = w_store ? ((r_issued + {2'b00, w_fire}) == w_size)
                                : ((r_recv + {2'b00, w_cap}) == w_size);

    mem_ld_ext u_ld_ext (
        .i_aluop (aluop_i),
        .i_buf   (r_buf),
        .o_wdata (w_ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_done_nxt ? ST_DONE : ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_done_nxt) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Byte counters, read-return tracking and load assembly buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issued  <= 3'd0;
            r_recv    <= 3'd0;
            r_buf     <= 32'h0000_0000;
            r_rd_pipe <= '0;
        end else if (r_state == ST_DONE) begin
            r_issued  <= 3'd0;
            r_recv    <= 3'd0;
            r_buf     <= 32'h0000_0000;
            r_rd_pipe <= '0;
        end else begin
            if (w_fire) begin
                r_issued <= r_issued + 3'd1;
            end else begin
                r_issued <= r_issued;
            end
            if (w_cap) begin
                r_recv                               <= r_recv + 3'd1;
                r_buf[{r_recv[1:0], 3'b000} +: 8]    <= mem_din_i;
            end else begin
                r_recv <= r_recv;
            end
            r_rd_pipe <= (r_rd_pipe << 1'b1) | RD_LAT'(w_fire && w_load);
        end
    end

    // Output decode; reset forces every output low without waiting for a clock
    always_comb begin
        mem_a_o    = 32'h0000_0000;
        mem_dout_o = 8'h00;
        mem_wr_o   = 1'b0;
        mem_req_o  = 1'b0;
        stall_o    = 1'b0;
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'h0000_0000;
        misalign_o = 1'b0;
        if (!rst) begin
            mem_req_o = 1'b0;
        end else if (!w_memop) begin
            wd_o    = wd_i;
            wreg_o  = wreg_i && (wd_i != 5'd0);
            wdata_o = wdata_i;
        end else begin
            case (r_state)
                ST_IDLE, ST_BUSY: begin
                    stall_o    = w_active;
                    misalign_o = (r_state == ST_IDLE) && w_misalign;
                    mem_req_o  = w_req;
                    if (w_req) begin
                        mem_a_o    = mem_addr_i + {29'd0, r_issued};
                        mem_wr_o   = w_store;
                        mem_dout_o = w_store ? wdata_i[{r_issued[1:0], 3'b000} +: 8] : 8'h00;
                    end else begin
                        mem_a_o = 32'h0000_0000;
                    end
                end
                ST_DONE: begin
                    wd_o    = wd_i;
                    wreg_o  = w_load && wreg_i && (wd_i != 5'd0);
                    wdata_o = w_load ? w_ld_data : 32'h0000_0000;
                end
                default: stall_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a byte-array memory and transaction-level model.
`timescale 1ns/1ps
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  aluop_i = 8'h00;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic        mem_gnt_i = 1'b0;
    logic [7:0]  mem_din_i = 8'h00;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o, mem_req_o, stall_o, wreg_o, misalign_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;

    always #5 clk = ~clk;

    mem_access #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .wdata_i(wdata_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .mem_gnt_i(mem_gnt_i), .mem_din_i(mem_din_i),
        .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o), .mem_req_o(mem_req_o),
        .stall_o(stall_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bit [7:0] mem [bit [31:0]];
    typedef struct { int due; bit [7:0] d; } rd_t;
    rd_t rdq[$];

    localparam logic [7:0] OPS [9] = '{MEM_NOP, EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU, EX_SB, EX_SH, EX_SW};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [7:0] mem_rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
    endfunction

    // One clock: memory returns the byte whose read latency expires, otherwise noise
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            mem_din_i = rdq[0].d;
            void'(rdq.pop_front());
        end else begin
            mem_din_i = 8'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic nop_op(input logic [31:0] data, input logic [4:0] wd, input logic wreg);
        aluop_i = MEM_NOP; wdata_i = data; wd_i = wd; wreg_i = wreg; mem_addr_i = $urandom;
        mem_gnt_i = 1'b1;
        #2;
        chk("nop_wdata", wdata_o, data);
        chk("nop_wreg", wreg_o, wreg && (wd != 5'd0));
        chk("nop_wd", wd_o, wd);
        chk("nop_stall", stall_o, 1'b0);
        chk("nop_req", mem_req_o, 1'b0);
        step();
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] drop_mask,
                          input int pct, output int stalls);
        int n;
        bit st, sgn, mis, finished;
        int issued, done_t;
        bit [31:0] raw, exp_w;
        n   = (op == EX_LB || op == EX_LBU || op == EX_SB) ? 1 : (op == EX_LH || op == EX_LHU || op == EX_SH) ? 2 : 4;
        st  = (op == EX_SB || op == EX_SH || op == EX_SW);
        sgn = (op == EX_LB || op == EX_LH);
        raw = 32'h0;
        for (int k = 0; k < n; k++) raw = raw + (32'(mem_rd(addr + 32'(k))) << (8 * k));
        if (st) exp_w = 32'h0;
        else if (n == 4) exp_w = raw;
        else if (sgn && raw[8*n-1]) exp_w = raw - (32'h1 << (8 * n));
        else exp_w = raw;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        aluop_i = op; mem_addr_i = addr; wdata_i = data; wd_i = wd; wreg_i = wreg;
        stalls = 0; issued = 0; done_t = -1; finished = 1'b0;
        if (mis) begin
            mem_gnt_i = 1'b1;
            #2;
            chk("mis_flag", misalign_o, 1'b1);
            chk("mis_req", mem_req_o, 1'b0);
            chk("mis_stall", stall_o, 1'b0);
            chk("mis_wreg", wreg_o, 1'b0);
            step();
            return;
        end
        for (int t = 0; t < 64; t++) begin
            mem_gnt_i = !drop_mask[t] && ($urandom_range(99) < pct);
            #2;
            if (t == done_t) begin
                chk("done_stall", stall_o, 1'b0);
                chk("done_req", mem_req_o, 1'b0);
                chk("done_wdata", wdata_o, exp_w);
                chk("done_wreg", wreg_o, !st && wreg && (wd != 5'd0));
                if (!st) chk("done_wd", wd_o, wd);
                chk("done_misalign", misalign_o, 1'b0);
                step();
                finished = 1'b1;
                break;
            end
            if (stall_o) stalls++;
            chk("busy_stall", stall_o, 1'b1);
            chk("busy_req", mem_req_o, issued < n);
            if (issued < n) begin
                chk("addr", mem_a_o, addr + 32'(issued));
                chk("wr", mem_wr_o, st);
                if (st) chk("dout", mem_dout_o, data[8*issued +: 8]);
                if (mem_gnt_i) begin
                    if (st) mem[addr + 32'(issued)] = data[8*issued +: 8];
                    else rdq.push_back('{due: cyc + RD_LAT, d: mem_rd(addr + 32'(issued))});
                    issued++;
                    if (issued == n) done_t = st ? t + 1 : t + RD_LAT + 1;
                end
            end
            step();
        end
        if (!finished) chk("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int stalls;
        logic [7:0] op;
        logic [31:0] addr;
        // Reset: a memory op is presented but every output stays low
        aluop_i = EX_LW; mem_addr_i = 32'h0000_0040; wdata_i = 32'h1234_5678; wd_i = 5'd3; wreg_i = 1'b1;
        mem_gnt_i = 1'b1;
        #2;
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_wreg", wreg_o, 1'b0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_addr", mem_a_o, 32'h0);
        @(negedge clk); @(negedge clk);
        aluop_i = MEM_NOP;
        rst = 1'b1;
        step();

        nop_op(32'h0000_1234, 5'd5, 1'b1);
        nop_op(32'hA5A5_0001, 5'd0, 1'b1);

        run_op(EX_SW, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 1'b1, 32'h0, 100, stalls);
        chk("sw_stalls", stalls, 4);
        chk("sw_mem_word", {mem_rd(32'h103), mem_rd(32'h102), mem_rd(32'h101), mem_rd(32'h100)}, 32'hDEAD_BEEF);

        mem[32'h200] = 8'h80;
        run_op(EX_LB, 32'h0000_0200, 32'h0, 5'd8, 1'b1, 32'h0, 100, stalls);
        chk("lb_stalls", stalls, 2);
        run_op(EX_LBU, 32'h0000_0200, 32'h0, 5'd8, 1'b1, 32'h0, 100, stalls);
        chk("lbu_stalls", stalls, 2);

        mem[32'h300] = 8'h11; mem[32'h301] = 8'h22; mem[32'h302] = 8'h33; mem[32'h303] = 8'h44;
        run_op(EX_LW, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 32'h0000_0006, 100, stalls);
        chk("lw_gap_stalls", stalls, 7);

        // Reset in the middle of a store: request drops at once, first byte stays written
        aluop_i = EX_SW; mem_addr_i = 32'h0000_0400; wdata_i = 32'hCAFE_F00D; wd_i = 5'd1; wreg_i = 1'b0;
        mem_gnt_i = 1'b1;
        #2;
        chk("mid_req0", mem_req_o, 1'b1);
        mem[32'h400] = 8'h0D;
        step();
        #2;
        chk("mid_addr1", mem_a_o, 32'h0000_0401);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", mem_req_o, 1'b0);
        chk("mid_rst_wr", mem_wr_o, 1'b0);
        chk("mid_rst_stall", stall_o, 1'b0);
        @(negedge clk);
        rst = 1'b1; aluop_i = MEM_NOP; rdq.delete();
        step();
        run_op(EX_LW, 32'h0000_0400, 32'h0, 5'd4, 1'b1, 32'h0, 100, stalls);
        chk("post_rst_lw_stalls", stalls, 5);

        run_op(EX_LW, 32'h0000_0302, 32'h0, 5'd6, 1'b1, 32'h0, 100, stalls);
        run_op(EX_SH, 32'hFFFF_FFFF, 32'h0000_9A7B, 5'd2, 1'b1, 32'h0, 100, stalls);

        for (int i = 0; i < 150; i++) begin
            op = OPS[$urandom_range(8)];
            addr = ($urandom_range(3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3))) : (32'h0000_0800 + 32'($urandom_range(63)));
            if (op == MEM_NOP) nop_op($urandom, 5'($urandom), 1'($urandom));
            else run_op(op, addr, $urandom, 5'($urandom), 1'($urandom), 32'h0, 70, stalls);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
